id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV64I decode stage. Consumes a fetched 32-bit instruction plus PC, reads the register file, builds immediates and selects operands.
- Registers opcode[6:2], func3, func7 bit, operand1 and operand2 in exactly the form the execute-stage ALU consumes.
- Also registers store data, destination register, write enable and control-flow target.
- Sits between fetch and execute, with valid/ready handshakes on both sides and a flush input.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the registered instruction and drop this cycle's input
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  64  instruction PC
- rs1_addr  out  5  regfile read address, comb = in_inst[19:15]
- rs2_addr  out  5  regfile read address, comb = in_inst[24:20]
- rs1_data  in  64  comb regfile read data
- rs2_data  in  64  comb regfile read data
- out_valid  out  1  registered instruction valid
- out_ready  in  1  execute accepts
- out_opcode  out  5  inst[6:2]
- out_func3  out  3  inst[14:12]
- out_func7  out  1  ALU sub/arith select
- out_operand1  out  64  ALU operand 1
- out_operand2  out  64  ALU operand 2
- out_store_data  out  64  rs2_data (for S-type)
- out_rd  out  5  inst[11:7]
- out_reg_write  out  1  writes rd
- out_pc  out  64  instruction PC
- out_target  out  64  branch/jump target
- out_illegal  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- Reset: clock `clk`, reset `rst`, synchronous, active-high. Every registered output clears to 0 on the first rising edge with rst=1, and out_valid=0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: 1 cycle, accept edge to out_valid.
- Registers update on accept. If out_ready && !in_valid, out_valid clears. If out_valid && !out_ready, all outputs hold stable.
- flush has priority over accept: next out_valid=0 and the input is not captured. rst has priority over flush.
- Immediates, sign-extended to 64 bits:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
- Operand select, by opcode[6:2]:
  - 01100 R, 01110 R_W, 11000 B: op1=rs1_data, op2=rs2_data.
  - 00100 I, 00110 I_W, 00000 load: op1=rs1_data, op2=I-imm.
  - 01000 S: op1=rs1_data, op2=S-imm.
  - 01101 LUI: op1=0, op2=U-imm.
  - 00101 AUIPC: op1=pc, op2=U-imm.
  - 11011 JAL, 11001 JALR: op1=pc, op2=J-imm / I-imm respectively.
  - Other opcodes: op1=op2=0.
- out_func7:
  - inst[30] for R and R_W.
  - inst[30] for I and I_W when func3=101.
  - 0 otherwise.
- out_target:
  - B: pc+B-imm
  - JAL: pc+J-imm
  - JALR: (rs1_data+I-imm) & ~1
  - otherwise 0
  - Arithmetic is modulo 2^64.
- out_reg_write = 1 for R, R_W, I, I_W, load, LUI, AUIPC, JAL, JALR, and only when rd!=0. It is 0 for S, B and unknown opcodes.
- No hazard detection or forwarding here; rs*_data is sampled in the accept cycle.

Optional Feature:
- Macro ID_ILLEGAL_INST_EN.
- Defined: out_illegal=1 registered with the instruction when any of these hold:
  - inst[1:0]!=11
  - opcode not in the 11 listed
  - B with func3 010/011
  - I_W/R_W with func3 not in {000,001,101}
  - JALR func3!=000
- Defined, when illegal: reg_write is forced 0 and the instruction still flows (out_valid=1).
- Not defined: out_illegal is tied 0 and no checks are built.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=0x10 -> next cycle:
  - out_valid=1, opcode=00100, func3=000, func7=0
  - op1=0x10, op2=0xFFFFFFFFFFFFFFFF
  - rd=5, reg_write=1
- SRAI x3,x2,4 (0x40415193), rs1_data=0x80 -> func3=101, func7=1, op2=0x404, rd=3.
- BEQ x1,x2,+8 (0x00208463), pc=0x1000, rs1=rs2=7 -> op1=op2=7, reg_write=0, out_target=0x1008.
- LUI x7,0x80000 (0x800003B7) -> op1=0, op2=0xFFFFFFFF80000000. Then hold out_ready=0 for 3 cycles while in_valid=1 with a new inst -> in_ready=0, outputs unchanged; out_ready=1 -> new inst appears one cycle later.
- flush=1 in the same cycle as an accept -> out_valid=0 next cycle. rst=1 mid-stream -> out_valid=0 and all outputs 0 next edge.
- With ID_ILLEGAL_INST_EN: inst=0x00000000 -> out_illegal=1, reg_write=0, out_valid=1. Without the macro: out_illegal=0.

Source files
------------

// File: rtl/id_stage.sv
// RV64I decode stage: regfile read, immediate build and ALU operand select, registered toward execute.
// Optional illegal-instruction detection is built when ID_ILLEGAL_INST_EN is defined.
module id_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic            out_func7,
    output logic [XLEN-1:0] out_operand1,
    output logic [XLEN-1:0] out_operand2,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_I_W   = 5'b00110;
    localparam logic [4:0] OP_S     = 5'b01000;
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_R_W   = 5'b01110;
    localparam logic [4:0] OP_B     = 5'b11000;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_JAL   = 5'b11011;

    logic [4:0]      opcode;
    logic [2:0]      func3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] op1, op2, target;
    logic            func7, reg_write, illegal, accept;

    logic            valid_d, valid_q;
    logic [4:0]      opcode_d, opcode_q, rd_d, rd_q;
    logic [2:0]      func3_d, func3_q;
    logic            func7_d, func7_q, reg_write_d, reg_write_q, illegal_d, illegal_q;
    logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q, store_d, store_q;
    logic [XLEN-1:0] pc_d, pc_q, target_d, target_q;

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    // Handshake: a transfer happens on a cycle where valid && ready; the
    // producer holds its payload stable while valid && !ready. The output
    // register can take a new instruction whenever it is empty or draining.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        opcode = in_inst[6:2];
        func3  = in_inst[14:12];
        imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        imm_b  = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                  in_inst[11:8], 1'b0};
        imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
        imm_j  = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};
        op1       = '0;
        op2       = '0;
        target    = '0;
        func7     = 1'b0;
        reg_write = 1'b0;
        case (opcode)
            OP_R, OP_R_W: begin
                op1 = rs1_data; op2 = rs2_data; func7 = in_inst[30]; reg_write = 1'b1;
            end
            OP_B: begin
                op1 = rs1_data; op2 = rs2_data; target = in_pc + imm_b;
            end
            OP_I, OP_I_W: begin
                op1 = rs1_data; op2 = imm_i; reg_write = 1'b1;
                func7 = (func3 == 3'b101) ? in_inst[30] : 1'b0;
            end
            OP_LOAD:  begin op1 = rs1_data; op2 = imm_i; reg_write = 1'b1; end
            OP_S:     begin op1 = rs1_data; op2 = imm_s; end
            OP_LUI:   begin op2 = imm_u; reg_write = 1'b1; end
            OP_AUIPC: begin op1 = in_pc; op2 = imm_u; reg_write = 1'b1; end
            OP_JAL: begin
                op1 = in_pc; op2 = imm_j; target = in_pc + imm_j; reg_write = 1'b1;
            end
            OP_JALR: begin
                op1 = in_pc; op2 = imm_i; reg_write = 1'b1;
                target = (rs1_data + imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1};
            end
            default: ;
        endcase
`ifdef ID_ILLEGAL_INST_EN
        illegal = (in_inst[1:0] != 2'b11);
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_S, OP_LUI, OP_AUIPC, OP_JAL: ;
            OP_B:         if (func3 == 3'b010 || func3 == 3'b011) illegal = 1'b1;
            OP_R_W, OP_I_W:
                if (func3 != 3'b000 && func3 != 3'b001 && func3 != 3'b101) illegal = 1'b1;
            OP_JALR:      if (func3 != 3'b000) illegal = 1'b1;
            default:      illegal = 1'b1;
        endcase
`else
        illegal = 1'b0;
`endif
        // x0 is never written; an illegal instruction must not update state either.
        reg_write = reg_write && (in_inst[11:7] != 5'd0) && !illegal;
    end

    always_comb begin
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        func3_d     = func3_q;
        func7_d     = func7_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        store_d     = store_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        pc_d        = pc_q;
        target_d    = target_q;
        illegal_d   = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            opcode_d    = opcode;
            func3_d     = func3;
            func7_d     = func7;
            op1_d       = op1;
            op2_d       = op2;
            store_d     = rs2_data;
            rd_d        = in_inst[11:7];
            reg_write_d = reg_write;
            pc_d        = in_pc;
            target_d    = target;
            illegal_d   = illegal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            func3_q     <= '0;
            func7_q     <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            pc_q        <= '0;
            target_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            func3_q     <= func3_d;
            func7_q     <= func7_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            store_q     <= store_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_opcode     = opcode_q;
    assign out_func3      = func3_q;
    assign out_func7      = func7_q;
    assign out_operand1   = op1_q;
    assign out_operand2   = op2_q;
    assign out_store_data = store_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = reg_write_q;
    assign out_pc         = pc_q;
    assign out_target     = target_q;
    assign out_illegal    = illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed decode vectors, backpressure, flush and reset.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_func7, out_reg_write, out_illegal;
    logic [31:0] in_inst;
    logic [63:0] in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, out_opcode, out_rd;
    logic [2:0]  out_func3;
    logic [63:0] out_operand1, out_operand2, out_store_data, out_pc, out_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_func3(out_func3), .out_func7(out_func7), .out_operand1(out_operand1),
        .out_operand2(out_operand2), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_pc(out_pc), .out_target(out_target),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                         input logic [63:0] r1, input logic [63:0] r2);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; in_pc = 64'h0; rs1_data = 64'h0; rs2_data = 64'h0;
        tick(); tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_op1", out_operand1, 64'd0);
        chk("rst_op2", out_operand2, 64'd0);
        chk("rst_target", out_target, 64'd0);
        rst = 1'b0;

        // ADDI x5,x1,-1
        drive(32'hFFF08293, 64'h100, 64'h10, 64'h55);
        #1;
        chk("addi_rs1_addr", {59'd0, rs1_addr}, 64'd1);
        chk("addi_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("addi_valid", {63'd0, out_valid}, 64'd1);
        chk("addi_opcode", {59'd0, out_opcode}, 64'b00100);
        chk("addi_func3", {61'd0, out_func3}, 64'd0);
        chk("addi_func7", {63'd0, out_func7}, 64'd0);
        chk("addi_op1", out_operand1, 64'h10);
        chk("addi_op2", out_operand2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", {59'd0, out_rd}, 64'd5);
        chk("addi_we", {63'd0, out_reg_write}, 64'd1);
        chk("addi_store", out_store_data, 64'h55);
        chk("addi_pc", out_pc, 64'h100);

        // SRAI x3,x2,4
        drive(32'h40415193, 64'h104, 64'h80, 64'h0);
        #1;
        chk("srai_rs1_addr", {59'd0, rs1_addr}, 64'd2);
        tick();
        chk("srai_func3", {61'd0, out_func3}, 64'b101);
        chk("srai_func7", {63'd0, out_func7}, 64'd1);
        chk("srai_op1", out_operand1, 64'h80);
        chk("srai_op2", out_operand2, 64'h404);
        chk("srai_rd", {59'd0, out_rd}, 64'd3);

        // BEQ x1,x2,+8
        drive(32'h00208463, 64'h1000, 64'd7, 64'd7);
        tick();
        chk("beq_opcode", {59'd0, out_opcode}, 64'b11000);
        chk("beq_op1", out_operand1, 64'd7);
        chk("beq_op2", out_operand2, 64'd7);
        chk("beq_we", {63'd0, out_reg_write}, 64'd0);
        chk("beq_target", out_target, 64'h1008);

        // JAL x1,+16
        drive(32'h010000EF, 64'h2000, 64'h0, 64'h0);
        tick();
        chk("jal_op1", out_operand1, 64'h2000);
        chk("jal_op2", out_operand2, 64'd16);
        chk("jal_target", out_target, 64'h2010);
        chk("jal_we", {63'd0, out_reg_write}, 64'd1);

        // JALR x0,8(x5): odd base checks bit-0 clear; rd=0 suppresses write
        drive(32'h00828067, 64'h3000, 64'h101, 64'h0);
        tick();
        chk("jalr_op1", out_operand1, 64'h3000);
        chk("jalr_op2", out_operand2, 64'd8);
        chk("jalr_target", out_target, 64'h108);
        chk("jalr_we", {63'd0, out_reg_write}, 64'd0);

        // LUI x7,0x80000
        drive(32'h800003B7, 64'h3004, 64'h1234, 64'h0);
        tick();
        chk("lui_op1", out_operand1, 64'd0);
        chk("lui_op2", out_operand2, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd", {59'd0, out_rd}, 64'd7);
        chk("lui_target", out_target, 64'd0);

        // Backpressure with SD x2,-8(x1) waiting
        out_ready = 1'b0;
        drive(32'hFE20BC23, 64'h3008, 64'hA000, 64'hBEEF);
        #1;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_op2", out_operand2, 64'hFFFF_FFFF_8000_0000);
            chk("stall_opcode", {59'd0, out_opcode}, 64'b01101);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("sd_opcode", {59'd0, out_opcode}, 64'b01000);
        chk("sd_op1", out_operand1, 64'hA000);
        chk("sd_op2", out_operand2, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd_store", out_store_data, 64'hBEEF);
        chk("sd_we", {63'd0, out_reg_write}, 64'd0);
        chk("sd_rd", {59'd0, out_rd}, 64'd24);

        // Flush alongside an accept: nothing captured
        flush = 1'b1;
        drive(32'hFFF08293, 64'h4000, 64'h10, 64'h0);
        tick();
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_no_capture", {59'd0, out_opcode}, 64'b01000);

        // Accept, then drain with no new input
        drive(32'hFFF08293, 64'h4000, 64'h10, 64'h0);
        tick();
        chk("post_flush_valid", {63'd0, out_valid}, 64'd1);
        chk("post_flush_pc", out_pc, 64'h4000);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Reset mid-stream beats a pending accept
        drive(32'h40415193, 64'h5000, 64'h80, 64'h0);
        tick();
        rst = 1'b1;
        drive(32'h010000EF, 64'h6000, 64'h0, 64'h0);
        tick();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_op2", out_operand2, 64'd0);
        chk("midrst_pc", out_pc, 64'd0);
        chk("midrst_func7", {63'd0, out_func7}, 64'd0);
        rst = 1'b0;

        // All-zero word
        drive(32'h00000000, 64'h7000, 64'h99, 64'h0);
        tick();
        chk("zero_valid", {63'd0, out_valid}, 64'd1);
        chk("zero_we", {63'd0, out_reg_write}, 64'd0);
`ifdef ID_ILLEGAL_INST_EN
        chk("zero_illegal", {63'd0, out_illegal}, 64'd1);
        // JALR x1 with func3=001 is illegal, so its write is suppressed
        drive(32'h008290E7, 64'h7004, 64'h0, 64'h0);
        tick();
        chk("jalr_f3_illegal", {63'd0, out_illegal}, 64'd1);
        chk("jalr_f3_we", {63'd0, out_reg_write}, 64'd0);
`else
        chk("zero_illegal", {63'd0, out_illegal}, 64'd0);
`endif
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
